// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC register, req/ack fetch handshake and a prefetch FIFO of {pc, inst} pairs.
// Optional build macro MISALIGN_TRAP_EN adds a sticky fetch_misalign trap on unaligned redirects.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSel,
    input  logic [31:0] alu_out,
    input  logic        inst_consume,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {
        BOOT,
        RUN
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        fifo_pc_q   [DEPTH];
    logic [31:0]        fifo_pc_d   [DEPTH];
    logic [31:0]        fifo_inst_q [DEPTH];
    logic [31:0]        fifo_inst_d [DEPTH];
    logic               trapped;
    logic               push;
    logic               pop;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign trapped        = misalign_q;
    assign fetch_misalign = misalign_q;
`else
    assign trapped = 1'b0;
`endif

    // A redirect cycle never requests, so the flush can never race a handshake.
    assign imem_req   = !rst && (state_q == RUN) && !PCSel && !trapped && (count_q < FULL_CNT);
    assign imem_addr  = fetch_pc_q;
    assign push       = imem_req && imem_ack;
    assign inst_valid = (count_q != '0);
    assign pop        = inst_consume && inst_valid;

    assign inst     = inst_valid ? fifo_inst_q[rd_ptr_q] : NOP_INST;
    assign pc       = inst_valid ? fifo_pc_q[rd_ptr_q]   : fetch_pc_q;
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d  = misalign_q;
`endif
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (PCSel) begin
                    count_d  = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
`ifdef MISALIGN_TRAP_EN
                    if (alu_out[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        fetch_pc_d = alu_out;
                    end else begin
                        fetch_pc_d = alu_out;
                    end
`else
                    fetch_pc_d = alu_out & ~32'h3;
`endif
                end else begin
                    if (push) begin
                        fifo_pc_d[wr_ptr_q]   = fetch_pc_q;
                        fifo_inst_d[wr_ptr_q] = imem_rdata;
                        wr_ptr_d              = wr_ptr_q + 1'b1;
                        fetch_pc_d            = fetch_pc_q + 32'd4;
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                    case ({push, pop})
                        2'b10:   count_d = count_q + 1'b1;
                        2'b01:   count_d = count_q - 1'b1;
                        default: count_d = count_q;
                    endcase
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_inst_q[i] <= '0;
            end
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_inst_q <= fifo_inst_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

endmodule
